// File: rtl/dsp_mac_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// dsp_mac_sequencer_pkg
// Shared definitions for the DSP48A1 dot-product sequencer:
//   - OPMODE constants driven to the slice
//   - 2-bit FSM state encoding
//   - per-stage tag layout {vld, first, last}
//   - latency helper: L = IN_REGS + MREG + 1
// -----------------------------------------------------------------------------
package dsp_mac_sequencer_pkg;

    // X = M, Z = 0 : P <= M (start of a new vector)
    localparam logic [7:0] OPM_LOAD_M = 8'h01;
    // X = M, Z = P : P <= P + M (accumulate)
    localparam logic [7:0] OPM_ACC_M  = 8'h09;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // Control tag that travels alongside each operand pair through the slice.
    typedef struct packed {
        logic vld;    // a real element occupies this stage (0 = bubble)
        logic first;  // element 0 of the vector: load P instead of accumulating
        logic last;   // final element of the vector
    } tag_t;

    // Cycles from accept (stage 0) up to and including the P-capture edge.
    function automatic int seq_latency(input int in_regs, input int mreg);
        return in_regs + mreg + 1;
    endfunction

endpackage

// File: rtl/dsp_mac_sequencer_tag_pipe.sv
// -----------------------------------------------------------------------------
// dsp_tag_pipe
// Tag shift register that mirrors the slice's A/B/M register stages so the
// control tag of an element arrives at the P stage together with its product.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   tag_in      tag at stage 0 (combinational from accept)
//   tag_out     tag at stage STAGES (i.e. stage L-1); tag_in when STAGES = 0
// -----------------------------------------------------------------------------
module dsp_tag_pipe
    import dsp_mac_sequencer_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  tag_t tag_in,
    output tag_t tag_out
);

    if (STAGES == 0) begin : g_pass
        // L = 1: the product reaches P on the accept edge, no delay needed.
        logic w_unused;
        assign w_unused = clk ^ rst_n;
        assign tag_out  = tag_in;
    end else begin : g_regs
        tag_t r_stage [STAGES];

        // NOTE: this array is reset on purpose -- a stale vld bit after reset
        // would pulse CEP and fold an in-flight product into the next result.
        // NOTE: non-blocking assignments make every stage sample its
        // neighbour's pre-edge value, which is what makes this a shift register.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < STAGES; i++) r_stage[i] <= '0;
            end else begin
                r_stage[0] <= tag_in;
                for (int i = 1; i < STAGES; i++) r_stage[i] <= r_stage[i-1];
            end
        end

        assign tag_out = r_stage[STAGES-1];
    end

endmodule

// File: rtl/dsp_mac_sequencer.sv
// -----------------------------------------------------------------------------
// dsp_mac_sequencer
// Control side of a DSP48A1 slice used as a dot-product MAC, P = sum A[i]*B[i].
// Operand data is wired straight to the slice; this block handles the stream
// handshake, per-element OPMODE, CEP, RSTP and hand-off of the finished result.
// Slice assumptions: OPMODEREG=0, PREG=1, IN_REGS A/B stages, MREG as given.
// Ports:
//   s_valid/s_last/s_ready  operand-pair stream (data sits on slice A/B)
//   dsp_opmode/dsp_cep/dsp_rstp  slice controls, aligned to the P-capture cycle
//   m_valid/m_ready         result handshake; slice P holds the dot product
//   res_len/len_sat         element count of the finished vector, saturation
// -----------------------------------------------------------------------------
module dsp_mac_sequencer
    import dsp_mac_sequencer_pkg::*;
#(
    parameter int IN_REGS = 1,
    parameter int MREG    = 1,
    parameter int CNT_W   = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic [7:0]       dsp_opmode,
    output logic             dsp_cep,
    output logic             dsp_rstp,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [CNT_W-1:0] res_len,
    output logic             len_sat
);

    localparam int               L       = seq_latency(IN_REGS, MREG);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    // With L = 1 the product is written to P on the accept edge itself, so an
    // accept during the RSTP cycle would be wiped; hold off until RSTP drops.
    localparam bit               READY_WAITS_RSTP = (L == 1);
    // Where the FSM goes once s_last is accepted.
    localparam state_t           ST_AFTER_LAST = (L == 1) ? ST_HOLD : ST_DRAIN;

    state_t           r_state;
    state_t           w_state_nxt;
    tag_t             w_tag_in;
    tag_t             w_tag_p;
    logic             w_ready;
    logic             w_accept;
    logic             r_rstp;
    logic [CNT_W-1:0] r_cnt;
    logic             r_len_sat;

    // ---------------------------------------------------------------- accept
    assign w_ready  = ((r_state == ST_IDLE) || (r_state == ST_ACCUM))
                      && !(READY_WAITS_RSTP && r_rstp);
    assign w_accept = s_valid && w_ready;

    assign w_tag_in = '{vld:   w_accept,
                        first: w_accept && (r_state == ST_IDLE),
                        last:  w_accept && s_last};

    dsp_tag_pipe #(
        .STAGES (L - 1)
    ) u_tag_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .tag_in  (w_tag_in),
        .tag_out (w_tag_p)
    );

    // ------------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // NOTE: the default assignment first guarantees every path assigns
    // w_state_nxt, so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_nxt = s_last ? ST_AFTER_LAST : ST_ACCUM;
            end
            ST_ACCUM: begin
                if (w_accept && s_last) w_state_nxt = ST_AFTER_LAST;
            end
            ST_DRAIN: begin
                // The last product is captured into P on this edge.
                if (w_tag_p.vld && w_tag_p.last) w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (m_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------- element counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_len_sat <= 1'b0;
        end else if (w_accept) begin
            if (r_state == ST_IDLE) begin
                r_cnt     <= CNT_ONE;
                r_len_sat <= 1'b0;
            end else if (r_cnt == CNT_MAX) begin
                // Count sticks at max; accumulation in the slice carries on.
                r_len_sat <= 1'b1;
            end else begin
                r_cnt <= r_cnt + CNT_ONE;
            end
        end
    end

    // RSTP is held through reset and for the first clock after release, so P
    // is cleared by a real clock edge before any product can land.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rstp <= 1'b1;
        else        r_rstp <= 1'b0;
    end

    // ---------------------------------------------------------------- outputs
    assign s_ready    = w_ready;
    assign dsp_cep    = w_tag_p.vld;
    assign dsp_opmode = (w_tag_p.vld && w_tag_p.first) ? OPM_LOAD_M : OPM_ACC_M;
    assign dsp_rstp   = r_rstp;
    assign m_valid    = (r_state == ST_HOLD);
    assign res_len    = r_cnt;
    assign len_sat    = r_len_sat;

endmodule
